// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: two-requester arbiter in front of a single GPIO memory port.
// Each transaction walks IDLE -> ISSUE -> WAIT -> RESP, one cycle per non-idle state.
// Writes to the read-only window RO_LO..RO_HI are suppressed and flagged with err.
// Optional feature macro: GPIO_ARB_ROUND_ROBIN_EN (round-robin between requesters;
// when undefined, requester 0 has fixed priority).
module gpio_bus_arbiter #(
  parameter logic [8:0] RO_LO = 9'd503,
  parameter logic [8:0] RO_HI = 9'd505
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req,
  input  logic       m0_we,
  input  logic [8:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_ack,
  output logic [7:0] m0_rdata,
  output logic       m0_err,
  input  logic       m1_req,
  input  logic       m1_we,
  input  logic [8:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_ack,
  output logic [7:0] m1_rdata,
  output logic       m1_err,
  output logic       mem_rw_select,
  output logic [8:0] mem_address,
  output logic [7:0] mem_data_in,
  input  logic [7:0] mem_data_out,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] grant_q;
  logic       we_q;
  logic [8:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] m0_rdata_q;
  logic [7:0] m1_rdata_q;
  logic       any_req;
  logic       take_m1;
  logic       addr_ro;

  assign any_req = m0_req | m1_req;
  assign addr_ro = (addr_q >= RO_LO) && (addr_q <= RO_HI);

`ifdef GPIO_ARB_ROUND_ROBIN_EN
  // Pointer remembers who won the last grant; 1 means m1, so m0 wins the first tie.
  logic last_m1;

  // Winner selection: on a tie, favour the requester that was not granted last.
  always_comb begin
    take_m1 = m1_req && (!m0_req || !last_m1);
  end

  // Pointer tracks the most recent grant, lone or contested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_m1 <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_m1 <= take_m1;
    end
  end
`else
  // Winner selection: m0 always wins when both request.
  always_comb begin
    take_m1 = m1_req && !m0_req;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the per-state strobes (write enable, ack, err).
  always_comb begin
    state_next    = state;
    mem_rw_select = 1'b0;
    m0_ack        = 1'b0;
    m1_ack        = 1'b0;
    m0_err        = 1'b0;
    m1_err        = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_rw_select = we_q && !addr_ro;
        state_next    = WAIT;
      end
      WAIT: begin
        state_next = RESP;
      end
      RESP: begin
        m0_ack     = grant_q[0];
        m1_ack     = grant_q[1];
        m0_err     = grant_q[0] && we_q && addr_ro;
        m1_err     = grant_q[1] && we_q && addr_ro;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the winner's request fields in IDLE so later input changes cannot disturb it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= 9'd0;
      wdata_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_q <= take_m1 ? 2'b10 : 2'b01;
            we_q    <= take_m1 ? m1_we : m0_we;
            addr_q  <= take_m1 ? m1_addr : m0_addr;
            wdata_q <= take_m1 ? m1_wdata : m0_wdata;
          end
        end
        RESP: begin
          grant_q <= 2'b00;
        end
        default: begin
          grant_q <= grant_q;
        end
      endcase
    end
  end

  // Capture memory read data at the end of WAIT into the owner's read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rdata_q <= 8'd0;
      m1_rdata_q <= 8'd0;
    end else if (state == WAIT) begin
      if (grant_q[0]) begin
        m0_rdata_q <= mem_data_out;
      end
      if (grant_q[1]) begin
        m1_rdata_q <= mem_data_out;
      end
    end
  end

  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign grant       = grant_q;
  assign busy        = (state != IDLE);
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;

endmodule
